// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver (LSB first, idle-high line) with a one-entry
// holding register read through a valid/ack handshake.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line bit rate
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx           serial line, asynchronous to clk, idle high
//   data         last received byte
//   data_valid   holding register contains an unread byte
//   data_ack     one-cycle pulse: consumer has taken data
//   overrun      sticky: a byte was overwritten before it was acked
//   frame_error  one-cycle pulse: stop bit sampled low
//   busy         receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       overrun,
  output logic       frame_error,
  output logic       busy
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int CNT_W     = $clog2(BIT_TICKS);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_TICKS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  generate
    if (BIT_TICKS < 4) begin : g_bad_baud
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [2:0]       idx_r;
  logic [2:0]       idx_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic             commit_s;
  logic             ferr_s;

  // Two-flop synchronizer for the asynchronous line; resets to idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM next-state, tick counter, bit index and shift register.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    commit_s    = 1'b0;
    ferr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Re-check the start bit mid-bit so short glitches are rejected.
        if (cnt_r == HALF_M1) begin
          cnt_nxt_s = '0;
          if (!rx_sync_r) begin
            state_nxt_s = ST_DATA;
            idx_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_M1) begin
          cnt_nxt_s   = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_nxt_s = {rx_sync_r, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_M1) begin
          cnt_nxt_s = '0;
          if (rx_sync_r) begin
            commit_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_s      = 1'b1;
            state_nxt_s = ST_BRK;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_BRK: begin
        // Hold here while the line stays low so a break gives one error only.
        cnt_nxt_s = '0;
        if (rx_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BRK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Holding register, handshake flags and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data        <= 8'h00;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (commit_s) begin
        data       <= shift_r;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end
      // An ack of the pending byte wins over a simultaneous overwrite.
      if (data_ack && data_valid) begin
        overrun <= 1'b0;
      end else if (commit_s && data_valid) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
      frame_error <= ferr_s;
      // Registered from the next state so it tracks the state exactly.
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       overrun;
  logic       frame_error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int ferr_count = 0;
  int ferr_base;
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .overrun(overrun), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error === 1'b1) ferr_count = ferr_count + 1;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BT) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 20; i++) begin
      if (data_valid === 1'b1) break;
      sync_edge();
    end
    check({tag, "_valid"}, data_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data, e);
    end
  endtask

  task automatic ack();
    data_ack = 1'b1;
    sync_edge();
    data_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) sync_edge();

    // Glitch: 3 low cycles is rejected at the mid-start re-check
    ferr_base = ferr_count;
    rx = 1'b0;
    repeat (3) sync_edge();
    rx = 1'b1;
    check("glitch_busy_mid", busy, 1);
    repeat (20) sync_edge();
    check("glitch_busy", busy, 0);
    check("glitch_valid", data_valid, 0);
    check("glitch_data", data, 8'h00);
    check("glitch_ferr", ferr_count - ferr_base, 0);

    // Frame 0xA5 with exact commit timing
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
    join_none
    repeat (97) @(posedge clk);
    #1;
    check("a5_valid_early", data_valid, 0);
    check("a5_busy_mid", busy, 1);
    sync_edge();
    check("a5_valid_rise", data_valid, 1);
    check("a5_busy_done", busy, 0);
    repeat (3) sync_edge();
    expect_byte("a5");
    check("a5_ferr", ferr_count - ferr_base, 0);
    check("a5_overrun", overrun, 0);
    ack();
    check("a5_ack_valid", data_valid, 0);

    // Bad stop bit, long break, then a good frame
    ferr_base = ferr_count;
    send_frame(8'h3C, 1'b0);
    repeat (50) sync_edge();
    check("brk_busy", busy, 1);
    check("brk_valid", data_valid, 0);
    check("brk_data", data, 8'hA5);
    rx = 1'b1;
    repeat (10) sync_edge();
    check("brk_idle", busy, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    expect_byte("f55");
    check("brk_ferr_once", ferr_count - ferr_base, 1);
    ack();

    // Overrun: two frames without ack
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    expect_byte("f11");
    check("f11_overrun", overrun, 0);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    expect_byte("f22");
    check("f22_overrun", overrun, 1);
    ack();
    check("ovr_ack_valid", data_valid, 0);
    check("ovr_ack_overrun", overrun, 0);

    // Ack in the same cycle as a commit
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1);
    expect_byte("f66");
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
    join_none
    repeat (97) @(posedge clk);
    #1;
    data_ack = 1'b1;
    sync_edge();
    data_ack = 1'b0;
    expect_byte("f77");
    check("f77_overrun", overrun, 0);
    repeat (3) sync_edge();
    check("f77_valid_held", data_valid, 1);

    // Reset during bit 4 of 0xF0
    fork
      send_frame(8'hF0, 1'b1);
    join_none
    repeat (55) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_busy", busy, 0);
    repeat (50) sync_edge();
    rst = 1'b0;
    repeat (5) sync_edge();
    check("post_rst_idle", busy, 0);
    ferr_base = ferr_count;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    expect_byte("f81");
    check("f81_ferr", ferr_count - ferr_base, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
